arb_rr_4_active_low: RTL and testbench

- Round-robin arbiter that shares one active-low select resource (2-to-4 active-low decoder) between 4 requesters.
- Requests and grants are active-low one-hot, so the grant bus drives active-low chip-selects directly.
- Grant is held until the owner releases or a hold limit expires.
- Enforced one-cycle all-high gap (break-before-make) between owners.

---
 rtl/arb_pkg.sv | 13 +
 rtl/arb_rr_4_active_low_decoder.sv | 20 ++
 rtl/arb_rr_4_active_low.sv | 116 +++++++++++
 tb/tb_arb_rr_4_active_low.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 4-way active-low round-robin arbiter.
package arb_pkg;

  localparam int         N_REQ    = 4;
  localparam logic [3:0] GNT_NONE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_rr_4_active_low_decoder.sv
// 2-to-4 decoder with active-low enable and active-low one-hot outputs.
module decoder_2_to_4_active_low (
  input  logic       i_enable_n,
  input  logic [1:0] i_sel,
  output logic [3:0] o_dec_n
);

  always_comb begin
    o_dec_n = 4'b1111;
    if (!i_enable_n) begin
      case (i_sel)
        2'd0:    o_dec_n = 4'b1110;
        2'd1:    o_dec_n = 4'b1101;
        2'd2:    o_dec_n = 4'b1011;
        default: o_dec_n = 4'b0111;
      endcase
    end
  end

endmodule

// File: rtl/arb_rr_4_active_low.sv
// Round-robin arbiter for 4 active-low requesters driving active-low chip-selects,
// with a hold limit and a mandatory one-cycle all-high gap between owners.
module arb_rr_4_active_low
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_n,
  input  logic [N_REQ-1:0] req_n,
  output logic [N_REQ-1:0] gnt_n,
  output logic [1:0]       gnt_id,
  output logic             busy,
  output logic             timeout_p
);

  // Handshake: a requester holds req_n[i] low while it wants the resource; it owns
  // the resource exactly while gnt_n[i] is low, and releases by raising req_n[i].

  arb_state_t       r_state;
  logic [3:0]       r_gnt_n;
  logic [1:0]       r_gnt_id;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic             r_busy;
  logic             r_timeout_p;

  arb_state_t       w_state_nxt;
  logic [3:0]       w_gnt_n_nxt;
  logic [1:0]       w_gnt_id_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic             w_timeout_nxt;
  logic             w_eligible;
  logic [1:0]       w_winner;
  logic [3:0]       w_dec_n;
  logic             w_owner_rel;
  logic             w_hold_done;

  // First low request searching last+1 .. last+4; descending loop lets the nearest win.
  function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] req_v_n,
                                         input logic [1:0]       last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = last + 2'(k);
      if (!req_v_n[idx]) rr_pick = idx;
    end
  endfunction

  assign w_eligible  = !enable_n && (req_n != GNT_NONE);
  assign w_winner    = rr_pick(req_n, r_gnt_id);
  assign w_owner_rel = req_n[r_gnt_id];
  assign w_hold_done = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));

  decoder_2_to_4_active_low u_dec (
    .i_enable_n (1'b0),
    .i_sel      (w_winner),
    .o_dec_n    (w_dec_n)
  );

  // gnt_id doubles as last_id: it always names the current or most recent owner.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_n_nxt   = GNT_NONE;
    w_gnt_id_nxt  = r_gnt_id;
    w_hold_nxt    = r_hold_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE, ST_GAP: begin
        if (w_eligible) begin
          w_state_nxt  = ST_GRANT;
          w_gnt_n_nxt  = w_dec_n;
          w_gnt_id_nxt = w_winner;
          w_hold_nxt   = '0;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (w_owner_rel || enable_n || w_hold_done) begin
          w_state_nxt   = ST_GAP;
          w_timeout_nxt = w_hold_done && !w_owner_rel && !enable_n;
        end else begin
          w_gnt_n_nxt   = r_gnt_n;
          w_hold_nxt    = r_hold_cnt + HOLD_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt_n     <= GNT_NONE;
      r_gnt_id    <= 2'd3;
      r_hold_cnt  <= '0;
      r_busy      <= 1'b0;
      r_timeout_p <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt_n     <= w_gnt_n_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_busy      <= (w_gnt_n_nxt != GNT_NONE);
      r_timeout_p <= w_timeout_nxt;
    end
  end

  assign gnt_n     = r_gnt_n;
  assign gnt_id    = r_gnt_id;
  assign busy      = r_busy;
  assign timeout_p = r_timeout_p;

endmodule

// File: tb/tb_arb_rr_4_active_low.sv
// Bench for arb_rr_4_active_low: vector table, corner-case sequences, random vs. model.
module tb_arb_rr_4_active_low;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic       enable_n;
  logic [3:0] req_n;
  logic [3:0] gnt_n;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout_p;

  int n_tests = 0;
  int n_fail  = 0;

  arb_rr_4_active_low #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable_n  (enable_n),
    .req_n     (req_n),
    .gnt_n     (gnt_n),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .timeout_p (timeout_p)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // owner = -1 when nobody holds the resource; held = cycles the owner has had it.
  int   m_owner;
  int   m_held;
  int   m_last;
  logic m_to;
  logic sb_on;
  logic [7:0] exp_q[$];

  function automatic logic [3:0] exp_gnt(input int owner);
    logic [3:0] v;
    v = 4'b1111;
    if (owner >= 0) v[owner] = 1'b0;
    return v;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 3;
    m_to    = 1'b0;
  endtask

  task automatic model_edge(input logic en_n, input logic [3:0] rq_n);
    logic rel;
    logic tout;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      rel  = rq_n[m_owner];
      tout = (m_held == MAX_HOLD);
      if (rel || en_n || tout) begin
        m_owner = -1;
        m_to    = tout && !rel && !en_n;
      end else begin
        m_held++;
      end
    end else if (!en_n && rq_n != 4'b1111) begin
      for (int k = 1; k <= 4; k++) begin
        if (m_owner < 0 && !rq_n[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
      end
      m_last = m_owner;
      m_held = 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge(enable_n, req_n);
    if (sb_on) exp_q.push_back({exp_gnt(m_owner), 2'(m_last), (m_owner >= 0), m_to});
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n    = 1'b0;
    enable_n = 1'b0;
    req_n    = 4'b1111;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] ei,
                       input logic eb, input logic et);
    n_tests++;
    if (gnt_n !== eg) begin n_fail++; $display("FAIL %s gnt_n: got %b want %b", name, gnt_n, eg); end
    n_tests++;
    if (gnt_id !== ei) begin n_fail++; $display("FAIL %s gnt_id: got %0d want %0d", name, gnt_id, ei); end
    n_tests++;
    if (busy !== eb) begin n_fail++; $display("FAIL %s busy: got %b want %b", name, busy, eb); end
    n_tests++;
    if (timeout_p !== et) begin n_fail++; $display("FAIL %s timeout_p: got %b want %b", name, timeout_p, et); end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       en_n;
    logic [3:0] req_n;
    logic [3:0] gnt_n;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vecs[16];

  task automatic fill_vecs();
    vecs[0]  = '{1'b0, 4'b1111, 4'b1111, 2'd3, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b1110, 4'b1110, 2'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'b1110, 4'b1110, 2'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'b1111, 4'b1111, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'b1111, 4'b1111, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'b0000, 4'b1101, 2'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'b0000, 4'b1111, 2'd1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'b0000, 4'b1111, 2'd1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'b0000, 4'b1011, 2'd2, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'b0000, 4'b1011, 2'd2, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'b1111, 4'b1111, 2'd2, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'b0111, 4'b0111, 2'd3, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 4'b0110, 4'b0111, 2'd3, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 4'b0000, 4'b1111, 2'd3, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 4'b0000, 4'b1111, 2'd3, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 4'b1110, 4'b1110, 2'd0, 1'b1, 1'b0};
  endtask

  // ---------------- scoreboard ----------------
  task automatic sb_check(input string name);
    logic [7:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: expected queue empty", name);
    end else begin
      e = exp_q.pop_front();
      n_tests--;
      check(name, e[7:4], e[3:2], e[1], e[0]);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] rq;
    sb_on = 1'b0;
    fill_vecs();
    reset_dut();
    check("reset", 4'b1111, 2'd3, 1'b0, 1'b0);

    // idle with no requests
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle", 4'b1111, 2'd3, 1'b0, 1'b0);
    end

    // vector table from a fresh reset
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      enable_n = vecs[i].en_n;
      req_n    = vecs[i].req_n;
      step();
      check($sformatf("vec%0d", i), vecs[i].gnt_n, vecs[i].id, vecs[i].busy, vecs[i].to);
    end

    // rotation between 0 and 2 under continuous requests, each timed out
    reset_dut();
    req_n = 4'b1010;
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        step();
        check($sformatf("rot_g%0d_c%0d", g, c), (g % 2 == 0) ? 4'b1110 : 4'b1011,
              (g % 2 == 0) ? 2'd0 : 2'd2, 1'b1, 1'b0);
      end
      step();
      check($sformatf("rot_gap%0d", g), 4'b1111, (g % 2 == 0) ? 2'd0 : 2'd2, 1'b0, 1'b1);
    end

    // release on the last allowed cycle: no timeout pulse
    reset_dut();
    req_n = 4'b1101;
    for (int c = 0; c < MAX_HOLD; c++) step();
    check("tvr_last", 4'b1101, 2'd1, 1'b1, 1'b0);
    req_n = 4'b1111;
    step();
    check("tvr_gap", 4'b1111, 2'd1, 1'b0, 1'b0);

    // asynchronous reset in the middle of a grant
    reset_dut();
    req_n = 4'b1011;
    step();
    check("arst_pre", 4'b1011, 2'd2, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("arst_now", 4'b1111, 2'd3, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req_n = 4'b0000;
    step();
    check("arst_after", 4'b1110, 2'd0, 1'b1, 1'b0);

    // randomized traffic against the model
    reset_dut();
    sb_on = 1'b1;
    rq = 4'b1111;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      enable_n = ($urandom_range(0, 15) == 0);
      req_n    = rq;
      step();
      sb_check($sformatf("rand%0d", i));
      n_tests++;
      if (busy !== (gnt_n != 4'b1111)) begin
        n_fail++;
        $display("FAIL rand%0d busy_inv: busy %b gnt_n %b", i, busy, gnt_n);
      end
    end
    sb_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
